// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states, instruction fields and branch table for the 8-bit core
package cpu_pkg;

  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_ANDI = 3'b011;
  localparam logic [2:0] OP_RLS  = 3'b100;
  localparam logic [2:0] OP_NOP  = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } ctrl_state_t;

  localparam int INSN_W  = 9;
  localparam int FIELD_W = 3;
  localparam int OPC_LSB = 6;
  localparam int FA_LSB  = 3;
  localparam int FB_LSB  = 0;

  // Branch targets; narrowed to the PC width where they are used.
  localparam int unsigned BR_LUT_0 = 0;
  localparam int unsigned BR_LUT_1 = 2;
  localparam int unsigned BR_LUT_2 = 4;
  localparam int unsigned BR_LUT_3 = 8;
  localparam int unsigned BR_LUT_4 = 16;
  localparam int unsigned BR_LUT_5 = 32;
  localparam int unsigned BR_LUT_6 = 64;
  localparam int unsigned BR_LUT_7 = 128;

  function automatic int unsigned br_lut_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return BR_LUT_0;
      3'd1:    return BR_LUT_1;
      3'd2:    return BR_LUT_2;
      3'd3:    return BR_LUT_3;
      3'd4:    return BR_LUT_4;
      3'd5:    return BR_LUT_5;
      3'd6:    return BR_LUT_6;
      default: return BR_LUT_7;
    endcase
  endfunction

  function automatic logic [2:0] insn_op(input logic [INSN_W-1:0] insn);
    return insn[OPC_LSB +: FIELD_W];
  endfunction

  function automatic logic [2:0] insn_fa(input logic [INSN_W-1:0] insn);
    return insn[FA_LSB +: FIELD_W];
  endfunction

  function automatic logic [2:0] insn_fb(input logic [INSN_W-1:0] insn);
    return insn[FB_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - combinational branch target table indexed by the B field
import cpu_pkg::*;

module branch_lut #(
  parameter int PC_W = 10
) (
  input  logic [2:0]      idx,
  output logic [PC_W-1:0] target
);

  always_comb begin
    target = PC_W'(br_lut_entry(idx));
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit core
import cpu_pkg::*;

module ctrl_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_rdata,
  output logic [2:0]      rf_ra_a,
  output logic [2:0]      rf_ra_b,
  input  logic [7:0]      rf_rd_a,
  input  logic [7:0]      rf_rd_b,
  output logic [2:0]      alu_op,
  output logic [7:0]      alu_in1,
  output logic [7:0]      alu_in2,
  input  logic [7:0]      alu_result,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic [7:0]      rf_wdata,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  ctrl_state_t     state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic [7:0]      res;
  logic            illegal_q;
  logic [2:0]      alu_op_q;
  logic [7:0]      alu_in1_q, alu_in2_q;

  logic [2:0]      op, fa, fb;
  logic [8:0]      dec_insn;
  logic [7:0]      exe_in2;
  logic            start_ok, is_wr_op, br_taken;
  logic [PC_W-1:0] lut_target;

  assign op = insn_op(ir);
  assign fa = insn_fa(ir);
  assign fb = insn_fb(ir);

  assign start_ok = start && (state == ST_IDLE || state == ST_HALTED);
  assign is_wr_op = (op == OP_XOR) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_RLS);
  // Branch decision comes from the registered result, not an ALU flag.
  assign br_taken = (op == OP_BEQ) && (res == 8'h00);
  assign exe_in2  = (op == OP_XOR || op == OP_BEQ) ? rf_rd_b : {5'b0, fb};

  branch_lut #(.PC_W(PC_W)) u_branch_lut (
    .idx    (fb),
    .target (lut_target)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HALTED: if (start_ok) state_nxt = ST_FETCH;
      ST_FETCH:           state_nxt = ST_DECODE;
      ST_DECODE:          state_nxt = ST_EXECUTE;
      ST_EXECUTE:         state_nxt = (op == OP_HALT || op == OP_ILL) ? ST_HALTED : ST_WRITEBACK;
      ST_WRITEBACK:       state_nxt = ST_FETCH;
      default:            state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= START_PC;
      ir        <= '0;
      res       <= '0;
      illegal_q <= 1'b0;
      alu_op_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start_ok) begin
            pc        <= START_PC;
            illegal_q <= 1'b0;
          end
        end
        ST_DECODE: ir <= imem_rdata;
        ST_EXECUTE: begin
          res       <= alu_result;
          alu_op_q  <= op;
          alu_in1_q <= rf_rd_a;
          alu_in2_q <= exe_in2;
          if (op == OP_ILL) illegal_q <= 1'b1;
        end
        ST_WRITEBACK: pc <= br_taken ? lut_target : pc + PC_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    // Register addresses must be valid while the ROM word is still on imem_rdata.
    dec_insn  = (state == ST_DECODE) ? imem_rdata : ir;
    imem_addr = pc;
    rf_ra_a   = insn_fa(dec_insn);
    rf_ra_b   = (insn_op(dec_insn) == OP_BEQ) ? 3'd0 : insn_fb(dec_insn);
    alu_op    = alu_op_q;
    alu_in1   = alu_in1_q;
    alu_in2   = alu_in2_q;
    if (state == ST_EXECUTE) begin
      alu_op  = op;
      alu_in1 = rf_rd_a;
      alu_in2 = exe_in2;
    end
    rf_we    = (state == ST_WRITEBACK) && is_wr_op && !reset;
    rf_waddr = rf_we ? fa : 3'd0;
    rf_wdata = rf_we ? res : 8'h00;
    busy     = (state == ST_FETCH) || (state == ST_DECODE) ||
               (state == ST_EXECUTE) || (state == ST_WRITEBACK);
    done     = (state == ST_HALTED);
    illegal  = illegal_q;
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - scoreboard bench with an instruction-level reference model
module tb_ctrl_sequencer;

  localparam int PC_W = 10;
  localparam logic [8:0] HALT_W = 9'b111_000_000;

  typedef struct packed { logic [2:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [2:0] op; logic [7:0] in1; logic [7:0] in2; } exec_t;
  typedef struct packed { logic [PC_W-1:0] pc; logic ill; } halt_t;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_rdata;
  logic [2:0]      rf_ra_a, rf_ra_b, alu_op, rf_waddr;
  logic [7:0]      rf_rd_a, rf_rd_b, alu_in1, alu_in2, alu_result, rf_wdata;
  logic            rf_we, busy, done, illegal;

  logic [8:0] rom [0:1023];
  logic [7:0] rf [0:7];
  logic [7:0] rf_init [0:7];
  logic       rf_load;

  wr_t   exp_wr[$];
  exec_t exp_exec[$];
  halt_t exp_halt[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    lut [8] = '{0, 2, 4, 8, 16, 32, 64, 128};

  ctrl_sequencer #(.PC_W(PC_W), .START_PC('0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .rf_ra_a(rf_ra_a), .rf_ra_b(rf_ra_b), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign rf_rd_a = rf[rf_ra_a];
  assign rf_rd_b = rf[rf_ra_b];

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int t;
    t = a;
    case (op)
      3'd0:    return a ^ b;
      3'd1:    return a - b;
      3'd2:    return a + b;
      3'd3:    return a & b;
      3'd4:    return 8'(((t << b[2:0]) | (t >> (8 - b[2:0]))) & 255);
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_in1, alu_in2);

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: instruction phase is counted from the rising edge of busy.
  initial begin
    int    phase;
    bit    busy_d, done_d;
    wr_t   w;
    exec_t e;
    halt_t h;
    phase = 0; busy_d = 0; done_d = 0;
    forever begin
      @(negedge clk); #1;
      if (busy && !busy_d) phase = 0;
      else if (busy) phase++;
      if (busy && (phase % 4) == 2) begin
        if (exp_exec.size() == 0) check("unexpected_execute", 1, 0);
        else begin
          e = exp_exec.pop_front();
          check("alu_op", alu_op, e.op);
          check("alu_in1", alu_in1, e.in1);
          check("alu_in2", alu_in2, e.in2);
        end
      end
      if (rf_we) begin
        if (exp_wr.size() == 0) check("unexpected_rf_we", rf_we, 0);
        else begin
          w = exp_wr.pop_front();
          check("rf_waddr", rf_waddr, w.a);
          check("rf_wdata", rf_wdata, w.d);
        end
      end
      if (done && !done_d) begin
        if (exp_halt.size() == 0) check("unexpected_halt", 1, 0);
        else begin
          h = exp_halt.pop_front();
          check("halt_pc", imem_addr, h.pc);
          check("halt_illegal", illegal, h.ill);
          check("halt_busy", busy, 0);
        end
      end
      busy_d = busy;
      done_d = done;
    end
  end

  // Instruction-level reference: runs the program on a copy of rf_init.
  task automatic model(output int n, output bit ok);
    logic [7:0] r [8];
    logic [8:0] insn;
    logic [2:0] op, a, b;
    logic [7:0] v;
    int         pc;
    wr_t        wq[$];
    exec_t      eq[$];
    halt_t      h;
    for (int i = 0; i < 8; i++) r[i] = rf_init[i];
    pc = 0; n = 0; ok = 0;
    for (int step = 0; step < 80; step++) begin
      insn = rom[pc];
      op = insn[8:6]; a = insn[5:3]; b = insn[2:0];
      eq.push_back('{op, r[a], (op == 3'd0) ? r[b] : (op == 3'd1) ? r[0] : {5'b0, b}});
      if (op == 3'd7 || op == 3'd6) begin
        h.pc = PC_W'(pc); h.ill = (op == 3'd6);
        n = step; ok = 1;
        break;
      end
      v = r[a];
      case (op)
        3'd0: v = r[a] ^ r[b];
        3'd2: v = 8'((int'(r[a]) + int'(b)) % 256);
        3'd3: v = r[a] & {5'b0, b};
        3'd4: for (int s = 0; s < int'(b); s++) v = {v[6:0], v[7]};
        default: ;
      endcase
      if (op == 3'd0 || op == 3'd2 || op == 3'd3 || op == 3'd4) begin
        wq.push_back('{a, v});
        r[a] = v;
      end
      if (op == 3'd1 && r[a] == r[0]) pc = lut[b];
      else pc = (pc + 1) % 1024;
    end
    if (ok) begin
      foreach (wq[i]) exp_wr.push_back(wq[i]);
      foreach (eq[i]) exp_exec.push_back(eq[i]);
      exp_halt.push_back(h);
    end
  endtask

  task automatic load_rf();
    @(negedge clk); rf_load = 1;
    @(negedge clk); rf_load = 0;
  endtask

  task automatic run_prog(input bit hold_start);
    int n, k;
    bit ok;
    load_rf();
    model(n, ok);
    check("model_terminates", ok, 1);
    @(negedge clk); start = 1;
    @(negedge clk); if (!hold_start) start = 0;
    #1;
    check("start_clears_illegal", illegal, 0);
    check("start_busy", busy, 1);
    k = 0;
    while (!done && k < 4 * n + 10) begin
      @(negedge clk);
      k++;
      if (k >= 4 * n + 2) start = 0;
      #1;
    end
    check("halt_latency", k, 4 * n + 3);
    start = 0;
    @(negedge clk); #2;
    check("wr_queue_drained", exp_wr.size(), 0);
    check("exec_queue_drained", exp_exec.size(), 0);
    check("halt_queue_drained", exp_halt.size(), 0);
    exp_wr.delete(); exp_exec.delete(); exp_halt.delete();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = HALT_W;
  endtask

  task automatic gen_random();
    int len, p;
    logic [2:0] op;
    clear_rom();
    len = $urandom_range(4, 20);
    for (int i = 0; i < len; i++) begin
      p = $urandom_range(0, 99);
      if (p < 5) op = 3'd6;
      else if (p < 10) op = 3'd7;
      else op = 3'($urandom_range(0, 5));
      rom[i] = {op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
    end
    for (int i = 0; i < 8; i++) rf_init[i] = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 2) == 0) rf_init[$urandom_range(1, 7)] = rf_init[0];
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    reset = 1; start = 0; rf_load = 0;
    clear_rom();
    for (int i = 0; i < 8; i++) rf_init[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("reset_imem_addr", imem_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_illegal", illegal, 0);
    check("reset_rf_we", rf_we, 0);
    check("reset_alu_op", alu_op, 0);
    check("reset_alu_in1", alu_in1, 0);
    check("reset_alu_in2", alu_in2, 0);
    check("reset_rf_ra_a", rf_ra_a, 0);
    reset = 0;

    // ADDI r1,3 then BEQ r2,r0 via LUT[3]; taken and not-taken variants.
    rom[0] = 9'b010_001_011;
    rom[1] = 9'b001_010_011;
    rf_init[0] = 8'd7; rf_init[1] = 8'd5; rf_init[2] = 8'd7;
    run_prog(0);
    check("beq_taken_pc", imem_addr, 8);
    check("addi_r1", rf[1], 8);
    rf_init[2] = 8'd6;
    run_prog(0);
    check("beq_not_taken_pc", imem_addr, 2);

    // RLS, wrapping ADDI, then illegal opcode; start held high while busy.
    clear_rom();
    rom[0] = 9'b100_011_001;
    rom[1] = 9'b010_100_011;
    rom[2] = 9'b110_000_000;
    rf_init[3] = 8'h81; rf_init[4] = 8'hFE;
    run_prog(1);
    check("rls_r3", rf[3], 8'h03);
    check("addi_wrap_r4", rf[4], 8'h01);
    check("illegal_sticky", illegal, 1);

    for (int t = 0; t < 25; t++) begin
      gen_random();
      model(n, ok);
      exp_wr.delete(); exp_exec.delete(); exp_halt.delete();
      if (ok) run_prog(t % 2 == 1);
    end

    // Reset during WRITEBACK of an ADDI must suppress the register write.
    clear_rom();
    rom[0] = 9'b010_001_011;
    rf_init[1] = 8'd5;
    load_rf();
    exp_exec.push_back('{3'd2, 8'd5, 8'd3});
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    #1;
    check("reset_in_wb_rf_we", rf_we, 0);
    @(negedge clk); reset = 0;
    #1;
    check("post_reset_busy", busy, 0);
    check("post_reset_done", done, 0);
    check("post_reset_imem_addr", imem_addr, 0);
    check("post_reset_rf_ra_a", rf_ra_a, 0);
    check("post_reset_alu_op", alu_op, 0);
    check("post_reset_alu_in2", alu_in2, 0);
    @(negedge clk); #1;
    check("reset_in_wb_r1_kept", rf[1], 5);
    check("reset_in_wb_exec_seen", exp_exec.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle fetch/decode/issue controller for the 8-bit core; the instruction-side counterpart of the ALU.
- Fetches 9-bit instructions from a synchronous instruction ROM and decodes them into ALU op codes, operands and register-file read/write controls.
- Evaluates branches from the ALU result, sequences the PC, and reports halt and illegal-opcode status.

Parameters:
PC_W, 10, program counter / instruction address width
START_PC, 0, PC value loaded on start

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin execution; honoured only in IDLE or HALTED
imem_addr  out  PC_W  instruction ROM address (current PC)
imem_rdata  in  9  ROM data, valid one cycle after imem_addr
rf_ra_a  out  3  register-file read address A
rf_ra_b  out  3  register-file read address B
rf_rd_a  in  8  read data A (combinational read)
rf_rd_b  in  8  read data B (combinational read)
alu_op  out  3  ALU operation code
alu_in1  out  8  ALU operand 1
alu_in2  out  8  ALU operand 2
alu_result  in  8  ALU result (combinational)
rf_we  out  1  register write enable, one-cycle pulse
rf_waddr  out  3  write address
rf_wdata  out  8  write data
busy  out  1  high in FETCH..WRITEBACK
done  out  1  high in HALTED
illegal  out  1  sticky; set on opcode 110, cleared on start or reset

Behaviour:
- Reset (synchronous, active-high) puts the block in IDLE with PC=START_PC. All outputs are 0 except imem_addr=START_PC. Reset in any state, mid-instruction included, aborts with no rf_we pulse.
- Instruction format: [8:6] opcode, [5:3] field A, [2:0] field B.
- Opcodes:
  - 000 XOR: r[A] = r[A] ^ r[B].
  - 001 BEQ: compare r[A] with r0; B indexes the branch LUT.
  - 010 ADDI: r[A] = r[A] + zext(B).
  - 011 ANDI: r[A] = r[A] & zext(B).
  - 100 RLS: r[A] = rotl(r[A], B).
  - 101 NOP.
  - 110 illegal.
  - 111 HALT.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
- IDLE/HALTED + start: PC=START_PC, illegal=0, go to FETCH.
- FETCH: imem_addr=PC; go to DECODE.
- DECODE: latch imem_rdata into IR; rf_ra_a=A, rf_ra_b=(opcode==BEQ)?0:B; go to EXECUTE.
- EXECUTE:
  - alu_op=opcode; alu_in1=rf_rd_a.
  - alu_in2 = rf_rd_b for XOR/BEQ, zext(B) otherwise.
  - Register alu_result into RES.
  - 111: go to HALTED. 110: set illegal, go to HALTED.
  - All other opcodes: go to WRITEBACK.
- WRITEBACK:
  - XOR/ADDI/ANDI/RLS: rf_we=1 for exactly this cycle, rf_waddr=A, rf_wdata=RES.
  - BEQ: taken iff RES==8'h00, evaluated inside this block (no ALU zero flag is used). Taken: PC=lut[B]. Not taken: PC=PC+1.
  - All others: PC=PC+1.
  - Go to FETCH.
- Latency: exactly 4 cycles per non-halting instruction. HALT is reached 3 cycles after entering FETCH.
- PC arithmetic is modulo 2^PC_W; all-ones PC wraps to 0 with no flag.
- ADDI result truncates to 8 bits (carry dropped).
- start while busy is ignored. start and reset in the same cycle: reset wins.
- alu_op/alu_in1/alu_in2 hold their values outside EXECUTE. Verification checks them only in EXECUTE.

Decomposition:
- Package cpu_pkg:
  - opcode localparams OP_XOR..OP_HALT (3-bit);
  - state enum ctrl_state_t;
  - instruction field slice constants;
  - branch LUT contents as 8 PC_W-wide constants: {0,2,4,8,16,32,64,128}.
- Sub-module branch_lut: combinational, 3-bit index in, PC_W target out; entries taken from cpu_pkg.

Test Plan:
- Reset then start; ROM[0]=010_001_011 (ADDI r1,3), r1=5 -> alu_op=010, alu_in2=3 in EXECUTE; rf_we pulse with waddr=1, wdata=8 four cycles after start; PC=1.
- BEQ taken: ROM[1]=001_010_011, r2=r0=7 -> RES=0, PC=8, no rf_we. Same with r2=6 -> PC=2.
- RLS: r3=8'b1000_0001, ROM=100_011_001 -> rf_wdata=8'b0000_0011. ADDI r4=8'hFE imm 3 -> 8'h01.
- HALT at ROM[2] -> done=1, busy=0 and imem_addr=2 three cycles after entering FETCH. Start then restarts at PC=0.
- Opcode 110 -> illegal=1, done=1, no rf_we. Next start clears illegal.
- Reset asserted in WRITEBACK of an ADDI -> no rf_we pulse, IDLE next cycle, outputs at reset values. Start held high during execution has no effect.
